mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs and issues

---
 rtl/mem_stage_lsu.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// MEM-stage load/store unit. It takes the EX/MEM pipeline register outputs,
// issues data-memory requests over a valid/ready request channel, waits on a
// valid-only response channel for loads, and holds the MEM/WB boundary flops
// that feed write-back. stall_o freezes EX/MEM and everything upstream while
// a memory operation is in flight.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : memory ops to non-word-aligned addresses are dropped. No
//               request is issued and addr_err_o pulses for one cycle while
//               the instruction retires without a register write.
//   undefined : no addr_err_o port. The low two address bits are cleared
//               before the request goes out.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active-low
//   alu_res_i        ALU result, also the load/store address
//   rt_data_i        store data
//   rd_i             destination register
//   mem_r_i          load (wins when w_mem_ena_i is also set)
//   w_mem_ena_i      store
//   w_reg_ena_i      register write enable
//   wb_sel_i         1: write back load data, 0: write back alu_res_i
//   dm_req_*         request channel (valid/ready, we, addr, wdata)
//   dm_resp_*        response channel (valid, rdata)
//   stall_o          hold EX/MEM and all upstream stages
//   wb_valid_o       wb_* carries a retired instruction
//   wb_data_o        write-back data
//   wb_rd_o          write-back register
//   wb_w_reg_ena_o   write-back enable, already gated with wb_valid_o
//   addr_err_o       misaligned access pulse (MEM_ALIGN_CHECK_EN only)
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] alu_res_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [RW-1:0] rd_i,
  input  logic          mem_r_i,
  input  logic          w_mem_ena_i,
  input  logic          w_reg_ena_i,
  input  logic          wb_sel_i,
  output logic          dm_req_valid_o,
  input  logic          dm_req_ready_i,
  output logic          dm_req_we_o,
  output logic [DW-1:0] dm_req_addr_o,
  output logic [DW-1:0] dm_req_wdata_o,
  input  logic          dm_resp_valid_i,
  input  logic [DW-1:0] dm_resp_rdata_i,
  output logic          stall_o,
  output logic          wb_valid_o,
  output logic [DW-1:0] wb_data_o,
  output logic [RW-1:0] wb_rd_o,
  output logic          wb_w_reg_ena_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic          addr_err_o
`endif
);

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } state_e;

  state_e        state_q, state_d;

  // Load context captured at request acceptance; EX/MEM stays stalled, but
  // keeping a private copy makes write-back independent of upstream inputs.
  logic [RW-1:0] ld_rd_q;
  logic          ld_w_reg_q;
  logic          ld_sel_q;
  logic [DW-1:0] ld_alu_q;

  logic          wb_valid_q;
  logic [DW-1:0] wb_data_q;
  logic [RW-1:0] wb_rd_q;
  logic          wb_w_reg_q;

  logic          mem_op;
  logic          is_store;
  logic          misaligned;
  logic          req_valid;
  logic          load_accept;
  logic          stall;

  // A simultaneous load and store decodes as a load so no write can escape.
  assign mem_op   = mem_r_i | w_mem_ena_i;
  assign is_store = w_mem_ena_i & ~mem_r_i;

`ifdef MEM_ALIGN_CHECK_EN
  logic addr_err_q;
  assign misaligned = mem_op & (alu_res_i[1:0] != 2'b00);
  assign addr_err_o = addr_err_q;
`else
  assign misaligned = 1'b0;
`endif

  // Request/stall decode. The request is combinational from EX/MEM, which
  // is held by our own stall, so valid/addr/wdata stay put until accepted.
  always_comb begin
    state_d     = state_q;
    req_valid   = 1'b0;
    load_accept = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          req_valid = 1'b1;
          if (is_store) begin
            stall = ~dm_req_ready_i;
          end else begin
            stall = 1'b1;
            if (dm_req_ready_i) begin
              load_accept = 1'b1;
              state_d     = WAIT_RESP;
            end
          end
        end
      end
      WAIT_RESP: begin
        stall = ~dm_resp_valid_i;
        if (dm_resp_valid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset is folded into valid so no request escapes while held in reset.
  assign dm_req_valid_o = req_valid & rst;
  assign dm_req_we_o    = req_valid & is_store;
  assign dm_req_addr_o  = {alu_res_i[DW-1:2], 2'b00};
  assign dm_req_wdata_o = rt_data_i;
  assign stall_o        = stall;

  // FSM state, load context and MEM/WB boundary. A stalled cycle leaves a
  // bubble; data/rd are held so only valid and the write enable change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      ld_w_reg_q <= 1'b0;
      ld_sel_q   <= 1'b0;
      ld_alu_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_w_reg_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load_accept) begin
        ld_rd_q    <= rd_i;
        ld_w_reg_q <= w_reg_ena_i;
        ld_sel_q   <= wb_sel_i;
        ld_alu_q   <= alu_res_i;
      end
      if (stall) begin
        wb_valid_q <= 1'b0;
        wb_w_reg_q <= 1'b0;
      end else if (state_q == WAIT_RESP) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= ld_sel_q ? dm_resp_rdata_i : ld_alu_q;
        wb_rd_q    <= ld_rd_q;
        wb_w_reg_q <= ld_w_reg_q;
      end else begin
        // Unstalled IDLE: ALU op, accepted store, or dropped misaligned op.
        // Only a plain ALU op is allowed to write the register file.
        wb_valid_q <= 1'b1;
        wb_data_q  <= alu_res_i;
        wb_rd_q    <= rd_i;
        wb_w_reg_q <= w_reg_ena_i & ~mem_op;
      end
`ifdef MEM_ALIGN_CHECK_EN
      addr_err_q <= (state_q == IDLE) && misaligned;
`endif
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_data_o      = wb_data_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_w_reg_ena_o = wb_w_reg_q & wb_valid_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Self-checking bench for mem_stage_lsu. Directed scenarios plus a randomized
// run, all compared against a transaction-level reference model that tracks
// only "is a load outstanding" and the instruction expected to retire next.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] aluRes;
   logic [DW-1:0] rtData;
   logic [RW-1:0] rd;
   logic          memR;
   logic          wMemEna;
   logic          wRegEna;
   logic          wbSel;
   logic          reqValid;
   logic          reqReady;
   logic          reqWe;
   logic [DW-1:0] reqAddr;
   logic [DW-1:0] reqWdata;
   logic          respValid;
   logic [DW-1:0] respRdata;
   logic          stall;
   logic          wbValid;
   logic [DW-1:0] wbData;
   logic [RW-1:0] wbRd;
   logic          wbWRegEna;
`ifdef MEM_ALIGN_CHECK_EN
   logic          addrErr;
`endif

   mem_stage_lsu #(.DW(DW), .RW(RW)) dut (
      .clk             (clk),
      .rst             (rst),
      .alu_res_i       (aluRes),
      .rt_data_i       (rtData),
      .rd_i            (rd),
      .mem_r_i         (memR),
      .w_mem_ena_i     (wMemEna),
      .w_reg_ena_i     (wRegEna),
      .wb_sel_i        (wbSel),
      .dm_req_valid_o  (reqValid),
      .dm_req_ready_i  (reqReady),
      .dm_req_we_o     (reqWe),
      .dm_req_addr_o   (reqAddr),
      .dm_req_wdata_o  (reqWdata),
      .dm_resp_valid_i (respValid),
      .dm_resp_rdata_i (respRdata),
      .stall_o         (stall),
      .wb_valid_o      (wbValid),
      .wb_data_o       (wbData),
      .wb_rd_o         (wbRd),
      .wb_w_reg_ena_o  (wbWRegEna)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .addr_err_o      (addrErr)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: one outstanding load plus the next expected retirement.
   logic          mBusy;
   logic [RW-1:0] mRd;
   logic          mWReg;
   logic          mSel;
   logic [DW-1:0] mAlu;
   logic          expValid;
   logic          expWReg;
   logic          expKnown;
   logic [DW-1:0] expData;
   logic [RW-1:0] expRd;
   logic          expErr;
   logic          lastStall;

   // Current EX/MEM instruction for the randomized run
   logic [DW-1:0] cAlu;
   logic [DW-1:0] cRt;
   logic [RW-1:0] cRd;
   logic          cMr;
   logic          cMw;
   logic          cWReg;
   logic          cSel;

   // Count one comparison and report it if observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Clear the model to its post-reset view of the world
   task automatic modelReset();
      mBusy     = 1'b0;
      mRd       = '0;
      mWReg     = 1'b0;
      mSel      = 1'b0;
      mAlu      = '0;
      expValid  = 1'b0;
      expWReg   = 1'b0;
      expKnown  = 1'b1;
      expData   = '0;
      expRd     = '0;
      expErr    = 1'b0;
      lastStall = 1'b0;
   endtask

   // Assert reset for a cycle without touching the EX/MEM inputs, then
   // release just after a rising edge so no edge sees stale inputs.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst wb_valid", 32'(wbValid), 32'd0);
      checkOutput("rst wb_wreg", 32'(wbWRegEna), 32'd0);
      checkOutput("rst wb_data", wbData, 32'd0);
      checkOutput("rst wb_rd", 32'(wbRd), 32'd0);
      checkOutput("rst req_valid", 32'(reqValid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rst hold wb_valid", 32'(wbValid), 32'd0);
      rst = 1'b1;
      modelReset();
   endtask

   // One pipeline cycle: drive the inputs, check the combinational request
   // and stall against the model, then check the MEM/WB flops after the edge.
   task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rdIn,
                                input logic mr, input logic mw, input logic wreg, input logic sel,
                                input logic ready, input logic rv, input logic [31:0] rdata);
      logic memOp;
      logic mis;
      logic eStall;
      logic eReq;
      logic eWe;
      logic busyNow;
      @(negedge clk);
      aluRes    = alu;
      rtData    = rt;
      rd        = rdIn;
      memR      = mr;
      wMemEna   = mw;
      wRegEna   = wreg;
      wbSel     = sel;
      reqReady  = ready;
      respValid = rv;
      respRdata = rdata;
      #1;
      memOp   = mr | mw;
`ifdef MEM_ALIGN_CHECK_EN
      mis     = memOp && (alu[1:0] != 2'b00);
`else
      mis     = 1'b0;
`endif
      eStall  = 1'b0;
      eReq    = 1'b0;
      eWe     = mw & ~mr;
      busyNow = mBusy;
      expErr  = 1'b0;
      if (!busyNow) begin
         if (!memOp) begin
            expValid = 1'b1; expData = alu; expRd = rdIn; expWReg = wreg; expKnown = 1'b1;
         end else if (mis) begin
            expValid = 1'b1; expWReg = 1'b0; expKnown = 1'b0; expErr = 1'b1;
         end else begin
            eReq = 1'b1;
            if (eWe) begin
               eStall = ~ready;
               if (ready) begin
                  expValid = 1'b1; expWReg = 1'b0; expKnown = 1'b0;
               end
            end else begin
               eStall = 1'b1;
               if (ready) begin
                  mBusy = 1'b1; mRd = rdIn; mWReg = wreg; mSel = sel; mAlu = alu;
               end
            end
         end
      end else begin
         eStall = ~rv;
         if (rv) begin
            expValid = 1'b1; expData = mSel ? rdata : mAlu; expRd = mRd; expWReg = mWReg; expKnown = 1'b1;
            mBusy = 1'b0;
         end
      end
      if (eStall) begin
         expValid = 1'b0;
         expWReg  = 1'b0;
      end
      lastStall = eStall;
      checkOutput("stall", 32'(stall), 32'(eStall));
      checkOutput("req_valid", 32'(reqValid), 32'(eReq));
      if (eReq) begin
         checkOutput("req_we", 32'(reqWe), 32'(eWe));
         checkOutput("req_addr", reqAddr, alu & 32'hFFFF_FFFC);
         if (eWe) checkOutput("req_wdata", reqWdata, rt);
      end
      @(posedge clk);
      #1;
      checkOutput("wb_valid", 32'(wbValid), 32'(expValid));
      checkOutput("wb_wreg", 32'(wbWRegEna), 32'(expWReg));
      if (expValid && expKnown) begin
         checkOutput("wb_data", wbData, expData);
         checkOutput("wb_rd", 32'(wbRd), 32'(expRd));
      end
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("addr_err", 32'(addrErr), 32'(expErr));
`endif
   endtask

   initial begin
      rst = 1'b0;
      aluRes = '0; rtData = '0; rd = '0; memR = 1'b0; wMemEna = 1'b0; wRegEna = 1'b0;
      wbSel = 1'b0; reqReady = 1'b0; respValid = 1'b0; respRdata = '0;
      modelReset();
      doReset();

      // ALU op retires next cycle with no stall
      applyStimulus(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t1 data", wbData, 32'h1234);
      checkOutput("t1 rd", 32'(wbRd), 32'd5);

      // Load from 0x40, accepted at once, response three cycles later
      applyStimulus(32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
      checkOutput("t2 data", wbData, 32'hDEADBEEF);

      // Store to 0x80 with ready held low for three cycles
      for (int i = 0; i < 3; i++)
         applyStimulus(32'h80, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(32'h80, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t3 wreg", 32'(wbWRegEna), 32'd0);

      // Reset while a load is outstanding; a late response must be ignored
      applyStimulus(32'h100, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      doReset();
      applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
      checkOutput("t4 data", wbData, 32'd0);

      // Back-to-back load then ALU op, response the cycle after accept
      applyStimulus(32'h44, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(32'h44, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11223344);
      checkOutput("t5 load data", wbData, 32'h11223344);
      applyStimulus(32'h55, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t5 alu data", wbData, 32'h55);

      // Store to a misaligned address
      applyStimulus(32'h42, 32'h12345678, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(32'h60, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Randomized run; EX/MEM inputs are held whenever the model expects a stall
      for (int n = 0; n < 800; n++) begin
         if (n == 400) doReset();
         if (!lastStall) begin
            int kind;
            kind  = $urandom_range(0, 3);
            cAlu  = $urandom;
            if ($urandom_range(0, 3) != 0) cAlu[1:0] = 2'b00;
            cRt   = $urandom;
            cRd   = RW'($urandom);
            cMr   = (kind == 1) || (kind == 3);
            cMw   = (kind == 2) || (kind == 3);
            cWReg = 1'($urandom);
            cSel  = 1'($urandom);
         end
         applyStimulus(cAlu, cRt, cRd, cMr, cMw, cWReg, cSel,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
